// File: rtl/eh2_posit_encode.sv
// Two-stage posit pack/round: stage 1 builds the regime run and classifies, stage 2 rounds
// to nearest-even, saturates and packs. Optional stats counters under POSIT_ENC_STATS_EN.
module eh2_posit_encode #(
  parameter int unsigned POSIT_LEN   = 16,
  parameter int unsigned ES          = 2,
  parameter int unsigned REGIME_BW   = 5,
  parameter int unsigned FRACTION_BW = POSIT_LEN - ES - 3,
  parameter int unsigned FRAC_W_GRS  = POSIT_LEN - ES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sgn,
  input  logic [REGIME_BW-1:0] in_reg,
  input  logic [ES-1:0]        in_exp,
  input  logic [FRAC_W_GRS-1:0] in_fra,
  input  logic                 in_zero,
  input  logic                 in_oflw,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [POSIT_LEN-1:0] out_posit,
  output logic                 out_inexact
`ifdef POSIT_ENC_STATS_EN
  ,
  output logic [15:0]          stat_round_cnt,
  output logic [15:0]          stat_sat_cnt
`endif
);

  localparam int unsigned W2     = 2 * POSIT_LEN;
  localparam int unsigned MagW   = POSIT_LEN - 1;
  localparam int unsigned TailW  = ES + FRAC_W_GRS;
  localparam int          SatMax = POSIT_LEN - 2;
  localparam int          SatMin = -(POSIT_LEN - 1);

  logic          s1_valid, s1_sgn, s1_zero, s1_nar, s1_smax, s1_smin;
  logic [W2-1:0] s1_body;
  logic          s2_valid, s2_sat;
  logic          adv1, adv2;

  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // Stage 1: regime run construction and classification
  int            k_int;
  logic [5:0]    run_len;
  logic [W2-1:0] tail_al, body_d;

  always_comb begin
    k_int   = int'($signed(in_reg));
    tail_al = {in_exp, in_fra, {(W2 - TailW){1'b0}}};
    run_len = '0;
    body_d  = '0;
    if (k_int >= 0) begin
      // k+1 ones then a terminating zero
      run_len = 6'(k_int + 1);
      body_d  = ~({W2{1'b1}} >> run_len) | (tail_al >> (run_len + 6'd1));
    end else begin
      // -k zeros then a terminating one
      run_len = 6'(-k_int);
      body_d  = ({1'b1, {(W2 - 1){1'b0}}} >> run_len) | (tail_al >> (run_len + 6'd1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sgn   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_smax  <= 1'b0;
      s1_smin  <= 1'b0;
      s1_body  <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sgn  <= in_sgn;
        s1_zero <= in_zero;
        s1_nar  <= in_oflw;
        s1_smax <= (k_int >= SatMax);
        s1_smin <= (k_int <= SatMin);
        s1_body <= body_d;
      end
    end
  end

  // Stage 2: round to nearest-even, clamp, apply sign
  logic [MagW-1:0]      mag, mag_rnd, mag_f;
  logic [POSIT_LEN-1:0] sum, posit_d;
  logic                 g, st, inexact_d, sat_d;

  always_comb begin
    mag       = s1_body[W2-1 -: MagW];
    g         = s1_body[W2-POSIT_LEN];
    st        = |s1_body[W2-POSIT_LEN-1:0];
    sum       = {1'b0, mag} + POSIT_LEN'(g & (st | mag[0]));
    if (sum[POSIT_LEN-1])   mag_rnd = {MagW{1'b1}};
    else if (sum == '0)     mag_rnd = MagW'(1);
    else                    mag_rnd = sum[MagW-1:0];
    mag_f     = mag_rnd;
    inexact_d = g | st;
    sat_d     = 1'b0;
    if (s1_smax) begin
      mag_f     = {MagW{1'b1}};
      inexact_d = 1'b1;
      sat_d     = 1'b1;
    end else if (s1_smin) begin
      mag_f     = MagW'(1);
      inexact_d = 1'b1;
      sat_d     = 1'b1;
    end
    posit_d = s1_sgn ? -{1'b0, mag_f} : {1'b0, mag_f};
    if (s1_nar) begin
      posit_d   = {1'b1, {MagW{1'b0}}};
      inexact_d = 1'b0;
      sat_d     = 1'b0;
    end else if (s1_zero) begin
      posit_d   = '0;
      inexact_d = 1'b0;
      sat_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      s2_sat      <= 1'b0;
      out_posit   <= '0;
      out_inexact <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sat      <= sat_d;
        out_posit   <= posit_d;
        out_inexact <= inexact_d;
      end
    end
  end

`ifdef POSIT_ENC_STATS_EN
  logic out_xfer;
  assign out_xfer = s2_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_round_cnt <= '0;
      stat_sat_cnt   <= '0;
    end else if (out_xfer) begin
      if (out_inexact && !s2_sat && stat_round_cnt != 16'hFFFF)
        stat_round_cnt <= stat_round_cnt + 16'd1;
      if (s2_sat && stat_sat_cnt != 16'hFFFF)
        stat_sat_cnt <= stat_sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eh2_posit_encode.sv
// Directed self-checking bench for eh2_posit_encode (stats ports when POSIT_ENC_STATS_EN).
module tb_eh2_posit_encode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sgn, in_zero, in_oflw;
  logic [4:0]  in_reg;
  logic [1:0]  in_exp;
  logic [13:0] in_fra;
  logic        out_valid, out_ready, out_inexact;
  logic [15:0] out_posit;
`ifdef POSIT_ENC_STATS_EN
  logic [15:0] stat_round_cnt, stat_sat_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  eh2_posit_encode dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sgn      (in_sgn),
    .in_reg      (in_reg),
    .in_exp      (in_exp),
    .in_fra      (in_fra),
    .in_zero     (in_zero),
    .in_oflw     (in_oflw),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_posit   (out_posit),
    .out_inexact (out_inexact)
`ifdef POSIT_ENC_STATS_EN
    ,
    .stat_round_cnt (stat_round_cnt),
    .stat_sat_cnt   (stat_sat_cnt)
`endif
  );

  // Drives one input into an empty pipe and waits (bounded) for its result.
  task automatic run_one(input logic sgn, input logic [4:0] k, input logic [1:0] e,
                         input logic [13:0] f, input logic z, input logic o,
                         output logic [15:0] p, output logic inx, output int lat);
    logic got;
    @(negedge clk);
    in_valid = 1'b1; in_sgn = sgn; in_reg = k; in_exp = e; in_fra = f;
    in_zero = z; in_oflw = o; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; got = 1'b0; p = 'x; inx = 1'bx;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        p = out_posit; inx = out_inexact; got = 1'b1;
      end
    end
    if (!got) lat = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sgn = 0; in_reg = 0; in_exp = 0; in_fra = 0; in_zero = 0; in_oflw = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_posit !== 16'h0 || out_inexact !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b p=%h i=%b want 0 0000 0", out_valid, out_posit,
               out_inexact);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] p; logic inx; int lat;
    run_one(0, 5'd0, 2'd0, 14'd0, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h4000 || inx !== 1'b0 || lat != 2) begin
      n_fail++;
      $display("FAIL one_pos: got %h i=%b lat=%0d want 4000 i=0 lat=2", p, inx, lat);
    end
    run_one(1, 5'd0, 2'd0, 14'd0, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'hC000 || inx !== 1'b0) begin
      n_fail++;
      $display("FAIL one_neg: got %h i=%b want c000 i=0", p, inx);
    end
    run_one(0, 5'd1, 2'd0, 14'd0, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h6000 || inx !== 1'b0) begin
      n_fail++;
      $display("FAIL k_plus1: got %h i=%b want 6000 i=0", p, inx);
    end
    run_one(0, 5'h1F, 2'd0, 14'd0, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h2000 || inx !== 1'b0) begin
      n_fail++;
      $display("FAIL k_minus1: got %h i=%b want 2000 i=0", p, inx);
    end
    run_one(0, 5'd0, 2'd3, 14'd0, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h5800 || inx !== 1'b0) begin
      n_fail++;
      $display("FAIL exp3: got %h i=%b want 5800 i=0", p, inx);
    end
  endtask

  task automatic test_rounding();
    logic [15:0] p; logic inx; int lat;
    run_one(0, 5'd0, 2'd0, {11'h001, 3'b100}, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h4002 || inx !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_up_even: got %h i=%b want 4002 i=1", p, inx);
    end
    run_one(0, 5'd0, 2'd0, {11'h000, 3'b100}, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h4000 || inx !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_stay_even: got %h i=%b want 4000 i=1", p, inx);
    end
    run_one(0, 5'd13, 2'd0, 14'd0, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h7FFE || inx !== 1'b0) begin
      n_fail++;
      $display("FAIL k13_exact: got %h i=%b want 7ffe i=0", p, inx);
    end
    // k=-14: 14 zeros then 1 fill the magnitude; exp=11 and fraction all lost -> round up
    run_one(0, 5'h12, 2'd3, 14'h3FFF, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h0002 || inx !== 1'b1) begin
      n_fail++;
      $display("FAIL km14_round: got %h i=%b want 0002 i=1", p, inx);
    end
  endtask

  task automatic test_special();
    logic [15:0] p; logic inx; int lat;
    run_one(0, 5'd3, 2'd1, 14'h155, 1, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h0000 || inx !== 1'b0) begin
      n_fail++;
      $display("FAIL zero: got %h i=%b want 0000 i=0", p, inx);
    end
    run_one(1, 5'd3, 2'd1, 14'h155, 1, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h0000 || inx !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_neg: got %h i=%b want 0000 i=0", p, inx);
    end
    run_one(0, 5'd0, 2'd0, 14'd0, 1, 1, p, inx, lat);
    n_tests++;
    if (p !== 16'h8000 || inx !== 1'b0) begin
      n_fail++;
      $display("FAIL nar_over_zero: got %h i=%b want 8000 i=0", p, inx);
    end
    run_one(1, 5'd15, 2'd0, 14'd0, 0, 1, p, inx, lat);
    n_tests++;
    if (p !== 16'h8000 || inx !== 1'b0) begin
      n_fail++;
      $display("FAIL nar_neg: got %h i=%b want 8000 i=0", p, inx);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] p; logic inx; int lat;
    run_one(0, 5'd15, 2'd0, 14'd0, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h7FFF || inx !== 1'b1) begin
      n_fail++;
      $display("FAIL satmax: got %h i=%b want 7fff i=1", p, inx);
    end
    run_one(1, 5'd14, 2'd0, 14'd0, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h8001 || inx !== 1'b1) begin
      n_fail++;
      $display("FAIL satmax_neg_k14: got %h i=%b want 8001 i=1", p, inx);
    end
    run_one(1, 5'h10, 2'd0, 14'd0, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'hFFFF || inx !== 1'b1) begin
      n_fail++;
      $display("FAIL satmin_neg: got %h i=%b want ffff i=1", p, inx);
    end
    run_one(0, 5'h11, 2'd0, 14'd0, 0, 0, p, inx, lat);
    n_tests++;
    if (p !== 16'h0001 || inx !== 1'b1) begin
      n_fail++;
      $display("FAIL satmin_km15: got %h i=%b want 0001 i=1", p, inx);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [4];
    int n_in, n_out, cyc;
    exp_q[0] = 16'h4000; exp_q[1] = 16'h4800; exp_q[2] = 16'h5000; exp_q[3] = 16'h5800;
    n_in = 0; n_out = 0; cyc = 0;
    while (n_out < 4 && cyc < 40) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (n_in < 4);
      in_sgn = 0; in_reg = 0; in_exp = 2'(n_in); in_fra = 0; in_zero = 0; in_oflw = 0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_tests++;
        if (in_ready !== 1'b0 || n_in != 2) begin
          n_fail++;
          $display("FAIL b2b_stall_ready: cyc=%0d got rdy=%b accepts=%0d want rdy=0 accepts=2",
                   cyc, in_ready, n_in);
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_posit !== exp_q[0]) begin
          n_fail++;
          $display("FAIL b2b_hold: cyc=%0d got v=%b %h want v=1 %h", cyc, out_valid, out_posit,
                   exp_q[0]);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (out_posit !== exp_q[n_out] || out_inexact !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_order[%0d]: got %h want %h", n_out, out_posit, exp_q[n_out]);
        end
        n_out++;
      end
      if (in_valid && in_ready) n_in++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (n_out != 4 || n_in != 4 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count: got in=%0d out=%0d v=%b want 4 4 0", n_in, n_out, out_valid);
    end
  endtask

  task automatic test_reset_full();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    in_sgn = 1; in_reg = 5'd15; in_exp = 0; in_fra = 0; in_zero = 0; in_oflw = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_before_rst: got v=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_posit !== 16'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_flush: got v=%b p=%h rdy=%b want 0 0000 1", out_valid, out_posit,
               in_ready);
    end
`ifdef POSIT_ENC_STATS_EN
    n_tests++;
    if (stat_round_cnt !== 16'h0 || stat_sat_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL stats_rst: got %h %h want 0000 0000", stat_round_cnt, stat_sat_cnt);
    end
`endif
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_ghost: got v=%b want 0", out_valid);
    end
  endtask

`ifdef POSIT_ENC_STATS_EN
  task automatic test_stats();
    logic [15:0] p; logic inx; int lat;
    run_one(0, 5'd0, 2'd0, {11'h0, 3'b100}, 0, 0, p, inx, lat);
    run_one(0, 5'd15, 2'd0, 14'd0, 0, 0, p, inx, lat);
    run_one(0, 5'd0, 2'd0, 14'd0, 0, 0, p, inx, lat);
    @(negedge clk);
    n_tests++;
    if (stat_round_cnt !== 16'd1 || stat_sat_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL stats_count: got %0d %0d want 1 1", stat_round_cnt, stat_sat_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sgn = 0; in_reg = 0; in_exp = 0; in_fra = 0; in_zero = 0; in_oflw = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_saturation();
    test_back_to_back();
    test_reset_full();
`ifdef POSIT_ENC_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
